ntt_sched: RTL

Two-requester scheduler for the shared ML-DSA `ntt` core. It arbitrates round-robin between two clients, each submitting a 256-coefficient forward or inverse transform. It streams the granted client's coefficients into the core's `i_ready`/`i_data` port, then routes the core's `o_valid`/`o_data` result stream back to that client. Only one job is in flight at a time; the core is never fed while it is still producing output.

---
 rtl/ntt_sched.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/ntt_sched.sv
// ntt_sched: two-client round-robin scheduler in front of a shared NTT core.
//
// A granted client's N_COEF coefficients are streamed into the core. The
// core's result stream is then routed back to that client. Only one job is
// in flight at a time.
//
// Ports
//   i_clk, i_rst        clock; synchronous active-high reset (shared with core)
//   i_req[1:0]          per-client request level, held until granted
//   i_intt[1:0]         per-client inverse-transform select, sampled at grant
//   i_data0, i_data1    client coefficient streams
//   o_gnt[1:0]          one-hot, high for N_COEF cycles while data is sampled
//   o_valid[1:0]        one-hot result strobe toward the owning client
//   o_data              result coefficient (shared by both clients)
//   o_done[1:0]         pulse on the last result beat of a job
//   o_busy              high whenever a job is in progress
//   o_err               sticky protocol / watchdog error
//   o_core_ready, o_core_intt, o_core_data   drive the core input side
//   i_core_valid, i_core_data                 core output side
module ntt_sched #(
  parameter int N_COEF   = 256,
  parameter int DW       = 32,
  parameter int WAIT_MAX = 4096
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [1:0]    i_req,
  input  logic [1:0]    i_intt,
  input  logic [DW-1:0] i_data0,
  input  logic [DW-1:0] i_data1,
  output logic [1:0]    o_gnt,
  output logic [1:0]    o_valid,
  output logic [DW-1:0] o_data,
  output logic [1:0]    o_done,
  output logic          o_busy,
  output logic          o_err,
  output logic          o_core_ready,
  output logic          o_core_intt,
  output logic [DW-1:0] o_core_data,
  input  logic          i_core_valid,
  input  logic [DW-1:0] i_core_data
);

  localparam int              WDW      = $clog2(WAIT_MAX + 1);
  localparam logic [8:0]      CNT_LAST = 9'(N_COEF - 1);
  localparam logic [WDW-1:0]  WD_LAST  = WDW'(WAIT_MAX - 1);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT, DRAIN} state_t;

  state_t         state;
  logic [8:0]     cnt;       // coefficients loaded, then result beats seen
  logic [WDW-1:0] wd;        // consecutive cycles without core output
  logic           own;       // client owning the current job
  logic           last;      // client served most recently
  logic           has_last;  // cleared by reset so client 0 wins the first tie
  logic           pick;
  logic [DW-1:0]  load_data;

  function automatic logic [1:0] lane(input logic sel);
    return sel ? 2'b10 : 2'b01;
  endfunction

  // NOTE: every variable assigned in an always_comb gets a default first, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    pick = i_req[1];
    if (i_req == 2'b11) pick = has_last ? ~last : 1'b0;
  end

  assign load_data = own ? i_data1 : i_data0;

  // NOTE: state registers use non-blocking assignments so every register
  // sees pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= IDLE;
      cnt          <= '0;
      wd           <= '0;
      own          <= 1'b0;
      last         <= 1'b0;
      has_last     <= 1'b0;
      o_gnt        <= '0;
      o_valid      <= '0;
      o_data       <= '0;
      o_done       <= '0;
      o_busy       <= 1'b0;
      o_err        <= 1'b0;
      o_core_ready <= 1'b0;
      o_core_intt  <= 1'b0;
      o_core_data  <= '0;
    end else begin
      o_valid <= 2'b00;
      o_done  <= 2'b00;
      unique case (state)
        IDLE: begin
          o_busy       <= 1'b0;
          o_core_ready <= 1'b0;
          if (i_core_valid) o_err <= 1'b1;   // stray core beat, discarded
          if (|i_req) begin
            state       <= LOAD;
            own         <= pick;
            last        <= pick;
            has_last    <= 1'b1;
            o_core_intt <= i_intt[pick];
            o_gnt       <= lane(pick);
            o_busy      <= 1'b1;
            cnt         <= '0;
          end
        end
        LOAD: begin
          if (i_core_valid) o_err <= 1'b1;
          // Request level is ignored here: a started load always completes.
          o_core_ready <= 1'b1;
          o_core_data  <= load_data;
          cnt          <= cnt + 9'd1;
          if (cnt == CNT_LAST) begin
            state <= WAIT;
            o_gnt <= 2'b00;
            cnt   <= '0;
            wd    <= '0;
          end
        end
        WAIT, DRAIN: begin
          o_core_ready <= 1'b0;
          if (i_core_valid) begin
            wd      <= '0;
            o_valid <= lane(own);
            o_data  <= i_core_data;
            if (cnt == CNT_LAST) begin
              o_done <= lane(own);
              state  <= IDLE;
              cnt    <= '0;
            end else begin
              cnt   <= cnt + 9'd1;
              state <= DRAIN;
            end
          end else if (wd == WD_LAST) begin
            // Watchdog abort: no o_done, `last` keeps its value.
            o_err  <= 1'b1;
            o_busy <= 1'b0;
            state  <= IDLE;
            cnt    <= '0;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
